// File: rtl/fetch_dec_skid_reg.sv
// -----------------------------------------------------------------------------
// fetch_dec_skid_reg
//   Fetch-to-decode pipeline register with valid/ready handshakes on both
//   sides. It has an optional second (skid) entry and a synchronous flush.
//   With SKID=1, in_ready is a flop, so there is no combinational path from
//   out_ready to in_ready. With SKID=0 there is one entry and in_ready is
//   combinational.
//
// Parameters
//   PC_W, INSTR_W, EXC_W : payload field widths
//   SKID                 : 1 = two entries and registered in_ready,
//                          0 = one entry and combinational in_ready
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   flush      synchronous kill of all held entries (redirect/trap)
//   in_valid   fetch presents an entry
//   in_ready   stage can accept this cycle
//   in_pc      pc from fetch
//   in_instr   instruction from fetch
//   in_exc     exception cause from fetch (passed through, not interpreted)
//   out_valid  entry available to decode
//   out_ready  decode consumes this cycle
//   out_pc     pc to decode
//   out_instr  instruction to decode
//   out_exc    exception cause to decode
// -----------------------------------------------------------------------------
module fetch_dec_skid_reg #(
  parameter int unsigned PC_W    = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned EXC_W   = 16,
  parameter int unsigned SKID    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc
);

  localparam bit USE_SKID = (SKID != 0);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [EXC_W-1:0]   exc;
  } entry_t;

  // The state is the number of held entries. FULL is reachable only with SKID=1.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;

  logic main_valid;
  logic accept;
  logic consume;
  logic main_load_in;
  logic main_load_skid;
  logic skid_load;

  assign in_entry   = {in_pc, in_instr, in_exc};
  assign main_valid = (state_q != EMPTY);
  assign accept     = in_valid && in_ready;
  assign consume    = main_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides any handshake in the same cycle
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) state_d = ONE;
        end
        ONE: begin
          if (accept && !consume && USE_SKID) state_d = FULL;
          else if (consume && !accept)        state_d = EMPTY;
        end
        FULL: begin
          if (consume) state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output and datapath-control decode
  always_comb begin
    out_valid      = main_valid;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        main_load_in = accept;
      end
      ONE: begin
        // A simultaneous accept and consume replaces main directly, so no bubble
        if (accept) begin
          if (consume || !USE_SKID) main_load_in = 1'b1;
          else                      skid_load    = 1'b1;
        end
      end
      FULL: begin
        main_load_skid = consume;
      end
      default: begin
        main_load_in = 1'b0;
      end
    endcase
  end

  // Payload storage; flush zeroes it so that a stale payload never survives a redirect
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_load_in) begin
        main_q <= in_entry;
      end else if (main_load_skid) begin
        main_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_entry;
      end
    end
  end

  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;
  assign out_exc   = main_q.exc;

  generate
    if (USE_SKID) begin : g_skid
      // in_ready is a flop equal to "skid will be empty", so it does not depend on out_ready
      logic in_ready_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != FULL);
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = !main_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_fetch_dec_skid_reg.sv
module tb_fetch_dec_skid_reg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned EXC_W   = 16;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [15:0] exc;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               out_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic [EXC_W-1:0]   in_exc;

  logic               rdy1, ov1, rdy0, ov0;
  logic [PC_W-1:0]    opc1, opc0;
  logic [INSTR_W-1:0] oin1, oin0;
  logic [EXC_W-1:0]   oex1, oex0;

  fetch_dec_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .EXC_W(EXC_W), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc),
    .out_valid(ov1), .out_ready(out_ready),
    .out_pc(opc1), .out_instr(oin1), .out_exc(oex1)
  );

  fetch_dec_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .EXC_W(EXC_W), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc),
    .out_valid(ov0), .out_ready(out_ready),
    .out_pc(opc0), .out_instr(oin0), .out_exc(oex0)
  );

  // Reference model: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0), plus the last value shown on out_*.
  ent_t q1[$];
  ent_t q0[$];
  ent_t hold1, hold0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t e1, e0;
    e1 = (q1.size() > 0) ? q1[0] : hold1;
    e0 = (q0.size() > 0) ? q0[0] : hold0;
    chk("skid1_in_ready",  64'(rdy1), 64'(q1.size() < 2));
    chk("skid1_out_valid", 64'(ov1),  64'(q1.size() > 0));
    chk("skid1_out_pc",    opc1,      e1.pc);
    chk("skid1_out_instr", 64'(oin1), 64'(e1.instr));
    chk("skid1_out_exc",   64'(oex1), 64'(e1.exc));
    chk("skid0_in_ready",  64'(rdy0), 64'((q0.size() == 0) || (out_ready === 1'b1)));
    chk("skid0_out_valid", 64'(ov0),  64'(q0.size() > 0));
    chk("skid0_out_pc",    opc0,      e0.pc);
    chk("skid0_out_instr", 64'(oin0), 64'(e0.instr));
    chk("skid0_out_exc",   64'(oex0), 64'(e0.exc));
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic [15:0] exc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    in_exc    = exc;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Check the current state, then advance one clock and update the model.
  task automatic step();
    bit   a1, c1, a0, c0;
    ent_t e;
    #1;
    check_all();
    a1 = in_valid && (q1.size() < 2);
    c1 = out_ready && (q1.size() > 0);
    a0 = in_valid && ((q0.size() == 0) || out_ready);
    c0 = out_ready && (q0.size() > 0);
    e  = {in_pc, in_instr, in_exc};
    @(posedge clk);
    if (rst || flush) begin
      q1.delete();
      q0.delete();
      hold1 = '0;
      hold0 = '0;
    end else begin
      if (c1) void'(q1.pop_front());
      if (a1) q1.push_back(e);
      if (q1.size() > 0) hold1 = q1[0];
      if (c0) void'(q0.pop_front());
      if (a0) q0.push_back(e);
      if (q0.size() > 0) hold0 = q0[0];
    end
    #1;
  endtask

  initial begin
    // Reset held for two cycles with a live input present
    rst = 1'b1;
    drive(1'b1, 64'h8000_0000, 32'h1234_5678, 16'h00ff, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    q1.delete(); q0.delete(); hold1 = '0; hold0 = '0;
    check_all();
    rst = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 16'h0, 1'b0, 1'b0);
    step();

    // Streaming with decode always ready
    drive(1'b1, 64'h1000, 32'h0000_0001, 16'h0, 1'b1, 1'b0); step();
    drive(1'b1, 64'h1004, 32'h0000_0002, 16'h0, 1'b1, 1'b0); step();
    drive(1'b1, 64'h1008, 32'h0000_0003, 16'h0, 1'b1, 1'b0); step();
    drive(1'b0, 64'h0,    32'h0,         16'h0, 1'b1, 1'b0); step();
    step();

    // Back-pressure fills the skid, then drains in order
    drive(1'b1, 64'h2000, 32'h0000_0010, 16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h2004, 32'h0000_0011, 16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h2008, 32'h0000_0012, 16'h0, 1'b0, 1'b0); step();
    step();
    drive(1'b1, 64'h2008, 32'h0000_0012, 16'h0, 1'b1, 1'b0); step();
    drive(1'b0, 64'h0,    32'h0,         16'h0, 1'b1, 1'b0); step();
    step();
    step();

    // Flush while full with a concurrent offer that must be discarded
    drive(1'b1, 64'h3000, 32'h0000_0020, 16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h3004, 32'h0000_0021, 16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h3008, 32'h0000_0022, 16'h0, 1'b0, 1'b1); step();
    drive(1'b0, 64'h0,    32'h0,         16'h0, 1'b1, 1'b0); step();
    step();

    // Exception cause passes through untouched
    drive(1'b1, 64'h4000, 32'h0000_0013, 16'h0002, 1'b1, 1'b0); step();
    drive(1'b0, 64'h0,    32'h0,         16'h0,    1'b0, 1'b0); step();
    step();

    // Single-entry mode: stalled entry blocks input, a ready decode reopens it
    drive(1'b0, 64'h0,    32'h0,         16'h0, 1'b1, 1'b0); step();
    drive(1'b1, 64'h5000, 32'h0000_0030, 16'h0, 1'b0, 1'b0); step();
    drive(1'b0, 64'h0,    32'h0,         16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h5004, 32'h0000_0031, 16'h0, 1'b1, 1'b0); step();
    drive(1'b0, 64'h0,    32'h0,         16'h0, 1'b1, 1'b0); step();

    // Reset while full drops both entries
    drive(1'b1, 64'h6000, 32'h0000_0040, 16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h6004, 32'h0000_0041, 16'h0, 1'b0, 1'b0); step();
    rst = 1'b1; step();
    rst = 1'b0;
    drive(1'b0, 64'h0,    32'h0,         16'h0, 1'b0, 1'b0); step();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(($urandom_range(0, 3) != 0),
            {$urandom(), $urandom()}, 32'($urandom()), 16'($urandom()),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
      step();
    end
    rst = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 16'h0, 1'b0, 1'b0);
    step();
    #1;
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
